// File: rtl/sample_jitter_pipe.sv
// sample_jitter_pipe: elastic pipeline applying hashed MSAA jitter to per-lane sample coordinates
module sample_jitter_pipe #(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int LANES      = 4,
    parameter int PIPE_DEPTH = 3,
    parameter int TRI_W      = 216,
    parameter int COL_W      = 72
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [TRI_W-1:0]          tri_i,
    input  logic [COL_W-1:0]          color_i,
    input  logic [LANES*SIGFIG-1:0]   samp_x_i,
    input  logic [LANES*SIGFIG-1:0]   samp_y_i,
    input  logic [LANES-1:0]          lane_valid_i,
    input  logic [3:0]                subSample_RnnnnU,
    input  logic                      jit_en_i,
    input  logic                      seed_load_i,
    input  logic [2*(RADIX-2)-1:0]    seed_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [TRI_W-1:0]          tri_o,
    output logic [COL_W-1:0]          color_o,
    output logic [LANES*SIGFIG-1:0]   samp_x_o,
    output logic [LANES*SIGFIG-1:0]   samp_y_o,
    output logic [LANES-1:0]          lane_valid_o,
    output logic                      mode_err_o
);
    localparam int HOW = RADIX - 2;
    localparam int HIW = 2 * (SIGFIG - 4);
    localparam int LW  = LANES * SIGFIG;
    localparam int DW  = TRI_W + COL_W + 2 * LW + LANES;

    logic [2*HOW-1:0]      seed;
    logic                  onehot;
    logic [1:0]            sh;
    logic [HOW-1:0]        mask;
    logic [LW-1:0]         jx, jy;
    logic [DW-1:0]         din;
    logic [PIPE_DEPTH-1:0] v, rdy;
    logic [DW-1:0]         d [PIPE_DEPTH];

    function automatic logic [HOW-1:0] fold(input logic [HIW-1:0] in);
        logic [HOW-1:0] h;
        h = '0;
        for (int j = 0; j < HIW; j++) h[j % HOW] = h[j % HOW] ^ in[j];
        return h;
    endfunction

    assign onehot = (subSample_RnnnnU != 4'd0) && ((subSample_RnnnnU & (subSample_RnnnnU - 4'd1)) == 4'd0);
    assign sh     = subSample_RnnnnU[3] ? 2'd0 : subSample_RnnnnU[2] ? 2'd1 : subSample_RnnnnU[1] ? 2'd2 : 2'd3;
    assign mask   = (jit_en_i && onehot) ? ({HOW{1'b1}} >> sh) : '0;

    // jitter is resolved at acceptance so mode, enable and seed travel with the beat
    always_comb begin
        logic [SIGFIG-1:0] xl, yl, ex, ey;
        logic [HOW-1:0]    hx, hy;
        jx = '0;
        jy = '0;
        for (int l = 0; l < LANES; l++) begin
            xl = samp_x_i[l*SIGFIG +: SIGFIG];
            yl = samp_y_i[l*SIGFIG +: SIGFIG];
            hx = fold({yl[SIGFIG-1:4], xl[SIGFIG-1:4]}) ^ seed[HOW-1:0];
            hy = fold({xl[SIGFIG-1:4], yl[SIGFIG-1:4]}) ^ seed[2*HOW-1:HOW];
            ex = '0;
            ey = '0;
            ex[HOW+1:0] = {hx & mask, 2'b00};
            ey[HOW+1:0] = {hy & mask, 2'b00};
            jx[l*SIGFIG +: SIGFIG] = xl | ex;
            jy[l*SIGFIG +: SIGFIG] = yl | ey;
        end
    end

    assign din = {tri_i, color_i, jx, jy, lane_valid_i};

    // a stage can take a beat if it or any later stage is empty, or the sink is draining
    always_comb begin
        logic r;
        rdy = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            r = out_ready_i;
            for (int j = k; j < PIPE_DEPTH; j++) r = r | !v[j];
            rdy[k] = r;
        end
    end

    // stage registers, seed register and sticky mode error
    always_ff @(posedge clk) begin
        if (rst) begin
            v          <= '0;
            seed       <= '0;
            mode_err_o <= 1'b0;
            for (int k = 0; k < PIPE_DEPTH; k++) d[k] <= '0;
        end else begin
            if (seed_load_i) seed <= seed_i;
            if (in_valid_i && rdy[0] && !onehot) mode_err_o <= 1'b1;
            if (rdy[0]) begin
                v[0] <= in_valid_i;
                if (in_valid_i) d[0] <= din;
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (rdy[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) d[k] <= d[k-1];
                end
            end
        end
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = v[PIPE_DEPTH-1];
    assign {tri_o, color_o, samp_x_o, samp_y_o, lane_valid_o} = d[PIPE_DEPTH-1];
endmodule

// File: tb/tb_sample_jitter_pipe.sv
// tb_sample_jitter_pipe: directed self-checking bench for sample_jitter_pipe
module tb_sample_jitter_pipe;
    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, jit_en, seed_load, out_valid, out_ready, mode_err;
    logic [215:0] tri_i, tri_o;
    logic [71:0]  color_i, color_o;
    logic [95:0]  samp_x_i, samp_y_i, samp_x_o, samp_y_o;
    logic [3:0]   lane_valid_i, lane_valid_o, sub;
    logic [15:0]  seed_i;
    int           checks = 0, errors = 0;
    int           sent, got;
    logic         acc, del, stall;
    logic [215:0] hold;

    sample_jitter_pipe dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .tri_i(tri_i), .color_i(color_i), .samp_x_i(samp_x_i), .samp_y_i(samp_y_i),
        .lane_valid_i(lane_valid_i), .subSample_RnnnnU(sub), .jit_en_i(jit_en),
        .seed_load_i(seed_load), .seed_i(seed_i), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .tri_o(tri_o), .color_o(color_o),
        .samp_x_o(samp_x_o), .samp_y_o(samp_y_o), .lane_valid_o(lane_valid_o),
        .mode_err_o(mode_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [23:0] x, input logic [23:0] y, input logic [3:0] s,
                        input logic jit, input logic [23:0] ex, input logic [23:0] ey);
        samp_x_i     = {4{x}};
        samp_y_i     = {4{y}};
        sub          = s;
        jit_en       = jit;
        tri_i        = {27{8'hA5}};
        color_i      = {9{8'h3C}};
        lane_valid_i = 4'b1010;
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        tick;
        in_valid  = 1'b0;
        seed_load = 1'b0;
        sub       = 4'b0010;
        jit_en    = ~jit;
        samp_x_i  = '0;
        samp_y_i  = '0;
        chk({tag, "_lat1"}, out_valid, 1'b0);
        tick;
        chk({tag, "_lat2"}, out_valid, 1'b0);
        tick;
        chk({tag, "_lat3"}, out_valid, 1'b1);
        chk({tag, "_x"}, samp_x_o, {4{ex}});
        chk({tag, "_y"}, samp_y_o, {4{ey}});
        chk({tag, "_lv"}, lane_valid_o, 4'b1010);
        chk({tag, "_tri"}, tri_o, {27{8'hA5}});
        chk({tag, "_col"}, color_o, {9{8'h3C}});
        tick;
        chk({tag, "_drain"}, out_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; jit_en = 1'b1; seed_load = 1'b0; seed_i = '0; out_ready = 1'b1;
        tri_i = '0; color_i = '0; samp_x_i = '0; samp_y_i = '0; lane_valid_i = '0; sub = 4'b1000;
        repeat (2) tick;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_err", mode_err, 1'b0);
        chk("rst_x", samp_x_o, '0);
        chk("rst_tri", tri_o, '0);
        rst = 1'b0;
        tick;
        chk("post_rst_ready", in_ready, 1'b1);

        beat("msaa1", 24'h000400, 24'h0, 4'b1000, 1'b1, 24'h000500, 24'h000010);
        beat("msaa_low", 24'h000400, 24'h0, 4'b0001, 1'b1, 24'h000400, 24'h000010);
        beat("jit_off", 24'h000400, 24'h0, 4'b1000, 1'b0, 24'h000400, 24'h0);
        chk("err_clean", mode_err, 1'b0);

        seed_load = 1'b1;
        seed_i    = 16'h0001;
        beat("seed_same", 24'h000400, 24'h0, 4'b1000, 1'b1, 24'h000500, 24'h000010);
        beat("seed_new", 24'h000400, 24'h0, 4'b1000, 1'b1, 24'h000504, 24'h000010);

        seed_load = 1'b1;
        seed_i    = 16'h0000;
        tick;
        seed_load = 1'b0;
        beat("illegal", 24'h000400, 24'h0, 4'b0110, 1'b1, 24'h000400, 24'h0);
        chk("err_set", mode_err, 1'b1);

        jit_en = 1'b0;
        sub    = 4'b1000;
        sent   = 0;
        got    = 0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            in_valid  = (sent < 10);
            tri_i     = 216'(sent);
            out_ready = (c % 3 == 0);
            #1;
            chk("bp_ready", in_ready, !((sent - got) == 3 && !out_ready));
            acc   = in_valid && in_ready;
            del   = out_valid && out_ready;
            stall = out_valid && !out_ready;
            hold  = tri_o;
            if (del) begin
                chk("bp_order", tri_o, 256'(got));
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (stall) begin
                chk("bp_hold_v", out_valid, 1'b1);
                chk("bp_hold_d", tri_o, hold);
            end
        end
        in_valid = 1'b0;
        chk("bp_count", 256'(got), 256'(10));
        chk("err_sticky", mode_err, 1'b1);

        out_ready = 1'b1;
        jit_en    = 1'b1;
        samp_x_i  = {4{24'h000400}};
        in_valid  = 1'b1;
        tick;
        tick;
        in_valid  = 1'b0;
        rst       = 1'b1;
        seed_load = 1'b1;
        seed_i    = 16'hFFFF;
        tick;
        rst       = 1'b0;
        seed_load = 1'b0;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_x", samp_x_o, '0);
        chk("mid_rst_err", mode_err, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("no_stale", out_valid, 1'b0);
        end
        beat("after_rst", 24'h000400, 24'h0, 4'b1000, 1'b1, 24'h000500, 24'h000010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sample_jitter_pipe.md
SAMPLE_JITTER_PIPE -- requirements
Module: sample_jitter_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Parameters (name, default, meaning) SHALL be:
- SIGFIG, 24, coordinate width.
- RADIX, 10, fractional bits.
- LANES, 4, samples per beat.
- PIPE_DEPTH, 3, register stages (>=1).
- TRI_W, 216, flattened triangle width.
- COL_W, 72, flattened colour width.
REQ-003 Derived values SHALL be HOW = RADIX-2 and HIW = 2*(SIGFIG-4).
REQ-004 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock.
- rst, in, 1, sync reset, active high.
- in_valid_i, in, 1, input beat valid.
- in_ready_o, out, 1, block accepts a beat.
- tri_i, in, TRI_W, triangle, passed through.
- color_i, in, COL_W, colour, passed through.
- samp_x_i, in, LANES*SIGFIG, signed x per lane.
- samp_y_i, in, LANES*SIGFIG, signed y per lane.
- lane_valid_i, in, LANES, per-lane sample valid.
- subSample_RnnnnU, in, 4, one-hot MSAA mode.
- jit_en_i, in, 1, jitter enable.
- seed_load_i, in, 1, load seed.
- seed_i, in, 2*HOW, new seed value.
- out_valid_o, out, 1, output beat valid.
- out_ready_i, in, 1, downstream accepts.
- tri_o, out, TRI_W, triangle out.
- color_o, out, COL_W, colour out.
- samp_x_o, out, LANES*SIGFIG, jittered x per lane.
- samp_y_o, out, LANES*SIGFIG, jittered y per lane.
- lane_valid_o, out, LANES, lane valids out.
- mode_err_o, out, 1, sticky illegal-mode flag.

Function
REQ-005 A beat SHALL be accepted on any rising edge where in_valid_i && in_ready_o, and delivered on any edge where out_valid_o && out_ready_i.
REQ-006 The pipeline SHALL be elastic: stage k SHALL be ready when it is empty or stage k+1 is ready, and the last stage SHALL be ready when it is empty or out_ready_i=1.
REQ-007 in_ready_o SHALL equal stage-0 ready, which SHALL be combinational from out_ready_i.
REQ-008 Bubbles SHALL collapse.
REQ-009 Unstalled latency SHALL be PIPE_DEPTH cycles from acceptance to out_valid_o.
REQ-010 Throughput SHALL be 1 beat per cycle.
REQ-011 Beat order SHALL be preserved, and no beat SHALL be dropped or duplicated.
REQ-012 While a beat is stalled (out_valid_o=1, out_ready_i=0), every output SHALL hold stable.
REQ-013 The hash for x in lane L SHALL be computed as follows:
- in = {y_L[SIGFIG-1:4], x_L[SIGFIG-1:4]}.
- h[i] = XOR of in[j] over all j with j mod HOW == i.
- The result SHALL then be XORed with seed[HOW-1:0].
REQ-014 The hash for y SHALL be computed the same way, with in = {x_L[SIGFIG-1:4], y_L[SIGFIG-1:4]}, XORed with seed[2*HOW-1:HOW].
REQ-015 The mask SHALL be selected as follows:
- subSample[3] -> 8'hFF.
- [2] -> 8'h7F.
- [1] -> 8'h3F.
- [0] -> 8'h1F.
- Other widths SHALL follow the same pattern: all ones shifted right by 0, 1, 2 or 3.
REQ-016 The mask SHALL be 0 when jit_en_i=0 or subSample_RnnnnU is not one-hot.
REQ-017 Output coordinate SHALL be coord | ({(h & mask), 2'b00} zero-extended to SIGFIG), in bitwise OR only with no carry.
REQ-018 Jitter SHALL be applied to every lane regardless of lane_valid_i.
REQ-019 lane_valid, tri and color SHALL pass through unchanged with the beat.
REQ-020 Mode, jit_en and seed SHALL be sampled at acceptance and carried with the beat; later changes SHALL NOT affect in-flight beats.
REQ-021 On seed_load_i=1 the seed register SHALL load seed_i at that edge.
REQ-022 A beat accepted on the same edge as a seed load SHALL use the old seed.
REQ-023 mode_err_o SHALL set on acceptance of a beat whose subSample_RnnnnU is not one-hot.
REQ-024 mode_err_o SHALL clear only on rst.

Reset
REQ-025 On rst the block SHALL set:
- all stage valids = 0, so out_valid_o=0.
- all output data = 0.
- seed = 0.
- mode_err_o = 0.
REQ-026 in_ready_o SHALL be 1 in the cycle after reset deasserts.
REQ-027 A reset asserted mid-stream SHALL discard all in-flight beats, with no output beat on the following cycle.
REQ-028 If rst and seed_load_i are asserted together, rst SHALL win.

Verification
REQ-029 The bench SHALL cover these directed scenarios (defaults; seed=0; jit_en=1):
- Jitter, MSAA=1: x=24'h000400, y=0, subSample=4'b1000 -> samp_x_o=24'h000500, samp_y_o=24'h000010 after exactly 3 cycles.
- Mode mask: same sample with subSample=4'b0001 -> x=24'h000400, y=24'h000010; with jit_en=0 -> x=24'h000400, y=0.
- Seed: load seed=16'h0001, then the same sample at MSAA=1 -> x=24'h000504, y=24'h000010; the same-edge beat -> the old result.
- Backpressure: stream 10 beats with out_ready_i toggling 1,0,0,1,... -> all 10 delivered in order, outputs stable while stalled, in_ready_o=0 only when full and stalled.
- Illegal mode: subSample=4'b0110 -> mask 0 (coordinates unchanged), mode_err_o=1 and staying set until rst.
- Reset mid-flight: 2 beats in flight, then rst for 1 cycle -> out_valid_o=0 and no stale beat ever emerges.
